// File: rtl/rioencoder_tracker.sv
// Multi-turn position tracker fed by the absolute-encoder receiver: merges angle/revs
// into a 48-bit position with zero offset, jump rejection, windowed velocity and link timeout.
module rioencoder_tracker #(
  parameter int ClkFrequency = 12000000,
  parameter int TimeoutUs    = 1000,
  parameter int MaxStep      = 16384,
  parameter int RejectLimit  = 3,
  parameter int VelShift     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] angle,
  input  logic [31:0] revs,
  input  logic        zero,
  output logic        out_valid,
  output logic [47:0] position,
  output logic [31:0] delta,
  output logic [31:0] velocity,
  output logic        stale,
  output logic        jump_fault
);

  localparam int TimeoutCyc = ClkFrequency / 1000000 * TimeoutUs;
  localparam int TmoW       = $clog2(TimeoutCyc + 1);
  localparam int RejW       = $clog2(RejectLimit + 1);
  localparam int WinW       = VelShift + 1;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_STALE = 2'd2;

  localparam logic signed [47:0] MaxStepS = 48'(MaxStep);
  localparam logic signed [47:0] SatHi    = 48'sh0000_7FFF_FFFF;
  localparam logic signed [47:0] SatLo    = 48'shFFFF_8000_0000;

  function automatic logic [31:0] sat32(input logic signed [47:0] v);
    if (v > SatHi)      return 32'h7FFF_FFFF;
    else if (v < SatLo) return 32'h8000_0000;
    else                return v[31:0];
  endfunction

  logic [1:0]             state;
  logic signed [47:0]     prev;
  logic signed [47:0]     offset;
  logic signed [47:0]     win_sum;
  logic [WinW-1:0]        win_cnt;
  logic [RejW-1:0]        rej_cnt;
  logic [TmoW-1:0]        tmo_cnt;

  logic signed [47:0]     raw;
  logic signed [47:0]     d;
  logic signed [47:0]     win_sum_acc;
  logic signed [47:0]     prev_nxt;
  logic signed [47:0]     offset_nxt;
  logic                   step_ok;
  logic                   tracking;
  logic                   load;
  logic                   track_acc;
  logic                   reject;
  logic                   accept;
  logic                   timeout;
  logic                   win_done;

  assign raw      = {revs, angle};
  assign d        = raw - prev;
  // NOTE: signed range test, so d = -2^47 (whose magnitude overflows) is rejected naturally.
  assign step_ok  = (d >= -MaxStepS) && (d <= MaxStepS);
  assign tracking = (state == ST_TRACK);

  // Any sample outside TRACK reloads; so does the final reject of a consecutive run.
  assign load      = in_valid && (!tracking ||
                     (!step_ok && rej_cnt == RejW'(RejectLimit - 1)));
  assign track_acc = in_valid && tracking && step_ok;
  assign reject    = in_valid && tracking && !step_ok;
  assign accept    = load || track_acc;
  assign timeout   = !in_valid && tracking && (tmo_cnt == TmoW'(TimeoutCyc - 1));

  assign prev_nxt    = accept ? raw : prev;
  assign offset_nxt  = zero ? prev_nxt : offset;
  assign win_sum_acc = win_sum + d;
  assign win_done    = (win_cnt == WinW'((1 << VelShift) - 1));

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      prev       <= '0;
      offset     <= '0;
      win_sum    <= '0;
      win_cnt    <= '0;
      rej_cnt    <= '0;
      tmo_cnt    <= '0;
      out_valid  <= 1'b0;
      position   <= '0;
      delta      <= '0;
      velocity   <= '0;
      stale      <= 1'b1;
      jump_fault <= 1'b0;
    end else begin
      out_valid <= accept;
      prev      <= prev_nxt;
      offset    <= offset_nxt;

      if (accept || zero)
        position <= prev_nxt - offset_nxt;

      if (in_valid)
        tmo_cnt <= '0;
      else if (tmo_cnt != TmoW'(TimeoutCyc))
        tmo_cnt <= tmo_cnt + 1'b1;

      // A zero request clears the fault even when it coincides with a rejected sample.
      if (zero)
        jump_fault <= 1'b0;
      else if (reject)
        jump_fault <= 1'b1;

      if (load) begin
        state   <= ST_TRACK;
        stale   <= 1'b0;
        delta   <= '0;
        win_sum <= '0;
        win_cnt <= '0;
        rej_cnt <= '0;
      end else if (track_acc) begin
        delta   <= sat32(d);
        rej_cnt <= '0;
        if (win_done) begin
          velocity <= sat32(win_sum_acc);
          win_sum  <= '0;
          win_cnt  <= '0;
        end else begin
          win_sum <= win_sum_acc;
          win_cnt <= win_cnt + 1'b1;
        end
      end else if (reject) begin
        rej_cnt <= rej_cnt + 1'b1;
      end else if (timeout) begin
        state    <= ST_STALE;
        stale    <= 1'b1;
        velocity <= '0;
        win_sum  <= '0;
        win_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rioencoder_tracker.sv
// Self-checking bench for rioencoder_tracker: directed scenarios plus random traffic,
// compared every cycle against a plain-arithmetic position/velocity model.
module tb_rioencoder_tracker;

  localparam int     T    = 12000;
  localparam int     MAXS = 16384;
  localparam int     RL   = 3;
  localparam int     WIN  = 16;
  localparam longint M48  = 64'h0000_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] angle = '0;
  logic [31:0] revs = '0;
  logic        zero = 1'b0;
  logic        out_valid;
  logic [47:0] position;
  logic [31:0] delta;
  logic [31:0] velocity;
  logic        stale;
  logic        jump_fault;

  rioencoder_tracker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .angle      (angle),
    .revs       (revs),
    .zero       (zero),
    .out_valid  (out_valid),
    .position   (position),
    .delta      (delta),
    .velocity   (velocity),
    .stale      (stale),
    .jump_fault (jump_fault)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: positions are plain signed integers, wrapped to 48 bits.
  bit     m_tracking;
  longint m_prev, m_off, m_pos, m_delta, m_vel, m_sum;
  int     m_cnt, m_rej, m_gap;
  bit     m_ov, m_stale, m_jf;

  function automatic longint s48(input longint x);
    longint y;
    y = x & M48;
    if (y[47]) y = y - (longint'(1) << 48);
    return y;
  endfunction

  function automatic longint sat32(input longint x);
    if (x > 64'sd2147483647)  return 64'sd2147483647;
    if (x < -64'sd2147483648) return -64'sd2147483648;
    return x;
  endfunction

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tracking = 0;
    m_prev = 0; m_off = 0; m_pos = 0; m_delta = 0; m_vel = 0; m_sum = 0;
    m_cnt = 0; m_rej = 0; m_gap = 0;
    m_ov = 0; m_stale = 1; m_jf = 0;
  endtask

  task automatic model_step(input bit iv, input logic [15:0] ang,
                            input logic [31:0] rv, input bit z);
    longint r, d;
    bit     load, acc;
    r    = longint'($signed(rv)) * 65536 + longint'(ang);
    d    = s48(r - m_prev);
    load = 0;
    acc  = 0;
    m_ov = 0;
    if (iv) begin
      if (!m_tracking) load = 1;
      else if (d >= -MAXS && d <= MAXS) acc = 1;
      else begin
        m_jf = 1;
        m_rej++;
        if (m_rej == RL) load = 1;
      end
    end
    if (iv) m_gap = 0;
    else if (m_gap < T) m_gap++;

    if (load) begin
      m_prev = r; m_delta = 0; m_sum = 0; m_cnt = 0; m_rej = 0;
      m_tracking = 1; m_stale = 0; m_ov = 1;
    end else if (acc) begin
      m_prev = r; m_delta = sat32(d); m_rej = 0; m_ov = 1;
      m_sum += d;
      m_cnt++;
      if (m_cnt == WIN) begin
        m_vel = sat32(m_sum); m_sum = 0; m_cnt = 0;
      end
    end else if (!iv && m_tracking && m_gap == T) begin
      m_tracking = 0; m_stale = 1; m_vel = 0; m_sum = 0; m_cnt = 0;
    end

    if (z) begin
      m_off = m_prev;
      m_jf  = 0;
    end
    if (load || acc || z) m_pos = s48(m_prev - m_off);
  endtask

  task automatic compare_all();
    check("out_valid",  out_valid,          m_ov);
    check("position",   $signed(position),  m_pos);
    check("delta",      $signed(delta),     m_delta);
    check("velocity",   $signed(velocity),  m_vel);
    check("stale",      stale,              m_stale);
    check("jump_fault", jump_fault,         m_jf);
  endtask

  // One clock: drive just after a falling edge, compare at the next falling edge.
  task automatic tick(input bit iv, input longint raw, input bit z);
    in_valid = iv;
    angle    = raw[15:0];
    revs     = raw[47:16];
    zero     = z;
    model_step(iv, angle, revs, z);
    @(negedge clk);
    compare_all();
    in_valid = 1'b0;
    zero     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0);
  endtask

  initial begin
    longint cur, step;

    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("rst_stale", stale, 1);
    rst_n = 1'b1;
    idle(3);

    // First sample loads without a jump check.
    cur = 64'h0000_0002_1000;
    tick(1, cur, 0);
    check("first_ov",    out_valid, 1);
    check("first_pos",   $signed(position), 64'sh0000_0002_1000);
    check("first_delta", $signed(delta), 0);
    check("first_stale", stale, 0);

    // Sixteen +100 steps complete one velocity window.
    for (int i = 0; i < 16; i++) begin
      cur = cur + 100;
      tick(1, cur, 0);
      check("step_delta", $signed(delta), 100);
    end
    check("vel_window", $signed(velocity), 1600);

    // Three consecutive +20000 jumps: two discarded, third resyncs.
    tick(1, cur + 20000, 0);
    check("jump1_ov",  out_valid, 0);
    check("jump1_pos", $signed(position), 64'sh21000 + 1600);
    check("jump1_jf",  jump_fault, 1);
    tick(1, cur + 20000, 0);
    check("jump2_ov",  out_valid, 0);
    tick(1, cur + 20000, 0);
    check("resync_ov",    out_valid, 1);
    check("resync_delta", $signed(delta), 0);
    check("resync_pos",   $signed(position), 64'sh21000 + 21600);
    check("resync_jf",    jump_fault, 1);
    cur = cur + 20000;

    // Zero request, then a +10 sample.
    tick(0, 0, 1);
    check("zero_pos", $signed(position), 0);
    check("zero_jf",  jump_fault, 0);
    cur = cur + 10;
    tick(1, cur, 0);
    check("after_zero_pos", $signed(position), 10);

    // Link timeout exactly TIMEOUT_CYC idle cycles after the last sample.
    idle(T - 1);
    check("pre_timeout_stale", stale, 0);
    idle(1);
    check("timeout_stale", stale, 1);
    check("timeout_vel",   $signed(velocity), 0);
    idle(5);

    // Reload after stale ignores the jump, then an angle wrap with revs carry.
    tick(1, 64'h0000_0002_FFC0, 0);
    check("reload_ov",    out_valid, 1);
    check("reload_stale", stale, 0);
    check("reload_delta", $signed(delta), 0);
    tick(1, 64'h0000_0003_0024, 0);
    check("wrap_delta", $signed(delta), 100);

    // Force a resync near the signed revs rollover, then step across it.
    for (int i = 0; i < RL; i++) tick(1, s48(64'h0000_7FFF_FFFF_FFC0), 0);
    tick(1, s48(64'h0000_8000_0000_0024), 0);
    check("rollover_delta", $signed(delta), 100);
    check("rollover_ov",    out_valid, 1);

    // MaxStep boundary: exactly MaxStep accepted, one more rejected.
    cur = m_prev + MAXS;
    tick(1, s48(cur), 0);
    check("max_step_ov",    out_valid, 1);
    check("max_step_delta", $signed(delta), MAXS);
    tick(1, s48(cur + MAXS + 1), 0);
    check("over_step_ov", out_valid, 0);
    check("over_step_jf", jump_fault, 1);
    tick(0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      bit iv, z;
      iv = ($urandom_range(0, 3) != 0);
      z  = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 15))
        0:       step = (($urandom_range(0, 1) != 0) ? 1 : -1) *
                        longint'($urandom_range(16385, 200000));
        1:       case ($urandom_range(0, 3))
                   0:       step = MAXS;
                   1:       step = -MAXS;
                   2:       step = MAXS + 1;
                   default: step = -MAXS - 1;
                 endcase
        default: step = longint'($urandom_range(0, 600)) - 300;
      endcase
      tick(iv, s48(m_prev + step), z);
    end

    // Asynchronous reset mid-window with jump_fault set.
    tick(1, s48(m_prev + 50000), 0);
    check("pre_reset_jf", jump_fault, 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_ov",    out_valid, 0);
    check("async_pos",   $signed(position), 0);
    check("async_delta", $signed(delta), 0);
    check("async_vel",   $signed(velocity), 0);
    check("async_stale", stale, 1);
    check("async_jf",    jump_fault, 0);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    idle(2);

    tick(1, s48(64'h1234_5678_9ABC), 0);
    check("post_reset_ov",    out_valid, 1);
    check("post_reset_pos",   $signed(position), 64'sh1234_5678_9ABC);
    check("post_reset_delta", $signed(delta), 0);
    for (int i = 0; i < 40; i++) tick(1, s48(m_prev + 37), 0);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
